// File: rtl/rr_mux_arbiter.sv
// 2:1 word mux, the leaf cell of the arbiter data-path tree.
// Purely combinational, no latency, no flow control.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

// Round-robin arbiter sharing one registered output channel between N_REQ requesters.
// Latency: one cycle from the accepting edge to out_data.
// Backpressure: while out_valid && !out_ready all req_ready are 0 and the pointer holds.
module rr_mux_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0] out_src,
  input  logic                     out_ready
);
  localparam int PW     = $clog2(N_REQ);
  localparam int LEAVES = 1 << PW;

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic             have_win;
  logic             space;
  logic             accept;
  logic [WIDTH-1:0] sel_data;

  assign space  = !out_valid || out_ready;
  assign accept = space && have_win && !rst;

  // Rotated scan; index is ptr+k folded once by compare so N_REQ need not be 2^n.
  always_comb begin
    logic [PW:0] idx;
    have_win = 1'b0;
    win      = '0;
    idx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N_REQ)) idx = idx - (PW+1)'(N_REQ);
      if (!have_win && req_valid[idx[PW-1:0]]) begin
        have_win = 1'b1;
        win      = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // Heap-ordered tree: node n has children 2n and 2n+1, leaves at LEAVES+i, root at 1.
  logic [WIDTH-1:0] node [1:2*LEAVES-1];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < N_REQ) begin : g_used
      assign node[LEAVES+i] = req_data[i*WIDTH +: WIDTH];
    end else begin : g_tied
      assign node[LEAVES+i] = '0;
    end
  end

  for (genvar d = 0; d < PW; d++) begin : g_lvl
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      mux2 #(.WIDTH(WIDTH)) u_mux (
        .a   (node[2*((1 << d) + j)]),
        .b   (node[2*((1 << d) + j) + 1]),
        .sel (win[PW-1-d]),
        .y   (node[(1 << d) + j])
      );
    end
  end

  assign sel_data = node[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_src   <= win;
      ptr       <= (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter at N_REQ=4 and N_REQ=3 with a reference model and scoreboard.
module tb_rr_mux_arbiter;
  logic        clk = 1'b0;
  logic        rst4, rst3;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        out_ready;

  logic [3:0]  ready4;
  logic        vld4;
  logic [7:0]  data4;
  logic [1:0]  src4;
  logic [2:0]  ready3;
  logic        vld3;
  logic [7:0]  data3;
  logic [1:0]  src3;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst4), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready4), .out_valid(vld4), .out_data(data4), .out_src(src4),
    .out_ready(out_ready)
  );

  rr_mux_arbiter #(.N_REQ(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid[2:0]), .req_data(req_data[23:0]),
    .req_ready(ready3), .out_valid(vld3), .out_data(data3), .out_src(src3),
    .out_ready(out_ready)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr;
  logic        m_valid;
  logic [9:0]  sb [$];
  int          src_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs were set after the falling edge; check, advance the model, cross the rising edge.
  task automatic tick(input int n);
    logic [3:0] rv, obs_rdy, exp_rdy;
    logic       obs_vld, space, hw;
    logic [7:0] obs_data;
    logic [1:0] obs_src, w;
    logic [9:0] e;
    int         idx;
    #1;
    rv       = (n == 4) ? req_valid : {1'b0, req_valid[2:0]};
    obs_rdy  = (n == 4) ? ready4 : {1'b0, ready3};
    obs_vld  = (n == 4) ? vld4 : vld3;
    obs_data = (n == 4) ? data4 : data3;
    obs_src  = (n == 4) ? src4 : src3;
    space    = !m_valid || out_ready;
    hw = 1'b0;
    w  = 2'd0;
    for (int k = 0; k < n; k++) begin
      idx = (m_ptr + k) % n;
      if (!hw && rv[idx]) begin
        hw = 1'b1;
        w  = idx[1:0];
      end
    end
    exp_rdy = (hw && space) ? (4'b0001 << w) : 4'b0000;
    chk("req_ready", obs_rdy, exp_rdy);
    chk("out_valid", obs_vld, m_valid);
    if (m_valid) begin
      chk("sb_depth", sb.size(), 1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk("out_src", obs_src, e[9:8]);
        chk("out_data", obs_data, e[7:0]);
        if (out_ready) begin
          void'(sb.pop_front());
          src_log.push_back(int'(obs_src));
        end
      end
    end
    if (hw && space) begin
      sb.push_back({w, req_data[w*8 +: 8]});
      m_ptr   = (int'(w) == n - 1) ? 0 : int'(w) + 1;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_seq(input string tag, input int len,
                         input int e0, input int e1, input int e2, input int e3, input int e4);
    int ex [5];
    ex = '{e0, e1, e2, e3, e4};
    chk({tag, "_len"}, src_log.size(), len);
    for (int i = 0; i < len && i < src_log.size(); i++)
      chk(tag, src_log[i], ex[i]);
    src_log.delete();
  endtask

  initial begin
    rst4 = 1'b1;
    rst3 = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'hA3A2A1A0;
    out_ready = 1'b1;
    m_ptr   = 0;
    m_valid = 1'b0;
    #3;
    chk("rst_ready4", ready4, 4'b0000);
    chk("rst_valid4", vld4, 1'b0);
    chk("rst_data4", data4, 8'h00);
    chk("rst_src4", src4, 2'd0);
    chk("rst_ready3", ready3, 3'b000);
    @(negedge clk);
    @(negedge clk);

    // Reset lands while a word sits stalled in the output register.
    rst4 = 1'b0;
    req_valid = 4'b0001;
    out_ready = 1'b0;
    tick(4);
    tick(4);
    #2 rst4 = 1'b1;
    #1;
    chk("midrst_valid", vld4, 1'b0);
    chk("midrst_data", data4, 8'h00);
    chk("midrst_ready", ready4, 4'b0000);
    sb.delete();
    src_log.delete();
    m_ptr   = 0;
    m_valid = 1'b0;
    @(negedge clk);
    rst4 = 1'b0;

    // Rotation from a freshly reset pointer.
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick(4);
    req_valid = 4'b0000;
    tick(4);
    chk_seq("rot_src", 5, 0, 1, 2, 3, 0);

    // Grant 1, then the scan from 2 wraps to 0, then back to 1.
    req_valid = 4'b0010;
    tick(4);
    req_valid = 4'b0011;
    tick(4);
    tick(4);
    req_valid = 4'b0000;
    tick(4);
    chk_seq("wrap_src", 3, 1, 0, 1, 0, 0);

    // Five stalled cycles, then release.
    req_valid = 4'b1111;
    req_data  = 32'hB3B2B1B0;
    tick(4);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick(4);
    out_ready = 1'b1;
    tick(4);
    req_valid = 4'b0000;
    tick(4);
    chk_seq("bp_src", 2, 2, 3, 0, 0, 0);

    // Lone requester with changing data, then idle, then pointer check.
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      req_data[23:16] = 8'($urandom_range(0, 255));
      tick(4);
    end
    req_valid = 4'b0000;
    tick(4);
    req_valid = 4'b1001;
    req_data  = 32'hD3D2D1D0;
    tick(4);
    req_valid = 4'b0000;
    tick(4);
    tick(4);
    chk_seq("lone_src", 5, 2, 2, 2, 2, 3);
    chk("sb_drained4", sb.size(), 0);

    // Non-power-of-two instance.
    rst4 = 1'b1;
    rst3 = 1'b0;
    m_ptr   = 0;
    m_valid = 1'b0;
    req_valid = 4'b0111;
    req_data  = 32'h00C2C1C0;
    for (int i = 0; i < 5; i++) tick(3);
    req_valid = 4'b0000;
    tick(3);
    tick(3);
    chk_seq("n3_src", 5, 0, 1, 2, 0, 1);
    chk("sb_drained3", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
